circuit_tester: RTL and testbench
=================================

CIRCUIT_TESTER -- requirements
Module: circuit_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock cycles of settle time per input vector before sampling; legal range 0..15.
REQ-002 Parameter N_IN, default 3: DUT input count; truth-table width is 2**N_IN; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin one exhaustive sweep; sampled only in IDLE.
REQ-006 expected  input  2**N_IN  golden truth table; bit i = required DUT output for input vector i.
REQ-007 dut_in  output  N_IN  vector driven to the combinational DUT; MSB = A, then B, then C.
REQ-008 dut_f  input  1  DUT output, same clock domain, no synchronizer.
REQ-009 busy  output  1  high from the start edge until done rises.
REQ-010 done  output  1  one-cycle pulse at sweep end.
REQ-011 pass  output  1  captured equals latched expected; valid from done, held until next start.
REQ-012 captured  output  2**N_IN  measured truth table; bit i = dut_f sampled for vector i.
REQ-013 fail_valid  output  1  at least one mismatch in the last sweep.
REQ-014 fail_index  output  N_IN  lowest mismatching vector index; 0 when fail_valid is low.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE. Encoding is defined in the package.
REQ-016 IDLE with start=1 at edge E0: latch expected; clear captured, pass, fail_valid and fail_index; set dut_in=0 and settle counter=SETTLE_CYCLES; set busy=1; go to SETTLE (SAMPLE if SETTLE_CYCLES=0).
REQ-017 SETTLE: decrement the counter each edge; go to SAMPLE on the edge where the counter reaches 0.
REQ-018 SAMPLE edge: write dut_f to captured[dut_in].
REQ-019 SAMPLE edge, on mismatch with the latched expected bit: if fail_valid=0, set fail_valid=1 and fail_index=dut_in; later mismatches do not change fail_index.
REQ-020 SAMPLE edge, when dut_in < 2**N_IN-1: increment dut_in, reload the counter, return to SETTLE.
REQ-021 SAMPLE edge, when dut_in = 2**N_IN-1: go to DONE; dut_in wraps to 0.
REQ-022 Each vector is held on dut_in for exactly SETTLE_CYCLES+1 cycles; dut_f is sampled on the last edge of that window.
REQ-023 Latency: done is high in the cycle beginning at edge E0 + (2**N_IN)*(SETTLE_CYCLES+1) + 1.
REQ-024 In the done cycle, busy=0 and pass=(captured==expected latched at E0).
REQ-025 DONE lasts exactly one cycle, then returns to IDLE.
REQ-026 start while busy is ignored; expected changes after E0 are ignored.
REQ-027 start held high continuously restarts a sweep on the first IDLE cycle after DONE.
REQ-028 captured, pass, fail_valid and fail_index hold their values in IDLE until the next accepted start.

Reset
REQ-029 rst=1 immediately forces: state IDLE, dut_in=0, counter=0, busy=0, done=0, pass=0, captured=0, fail_valid=0, fail_index=0, latched expected=0.
REQ-030 rst mid-sweep abandons the sweep with no done pulse; the first start after rst deasserts begins a fresh sweep from vector 0.

Structure
REQ-031 A shared package holds the FSM state typedef/encoding, the default N_IN and SETTLE_CYCLES, and the counter width (4 bits).
REQ-032 The settle down-counter is one sub-module, settle_timer, with ports load, load_value, expired and rst/clk, instantiated once.
REQ-033 The top level contains the FSM, the vector register, the capture/compare logic and the output registers only.

Verification
REQ-034 DUT model F=(A&B)|(~A&C)|(A&~B&~C), expected=8'hDA, SETTLE=2, start at E0 -> done at E0+25, pass=1, captured=8'hDA, fail_valid=0.
REQ-035 Same DUT, expected=8'hDB -> captured=8'hDA, pass=0, fail_valid=1, fail_index=0.
REQ-036 DUT stuck-at-1, expected=8'hDA -> captured=8'hFF, fail_index=0, fail_valid=1. DUT stuck-at-0 -> captured=8'h00, fail_index=1.
REQ-037 SETTLE_CYCLES=0, DUT = identity on C, expected=8'hAA -> each vector held 1 cycle, done at E0+9, pass=1.
REQ-038 rst pulsed during vector 5 -> all outputs 0 asynchronously, no done; a new start gives a full correct sweep.
REQ-039 start pulsed at cycles 3 and 10 of a running sweep -> ignored, single done at the nominal cycle; start held high -> back-to-back sweeps separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/circuit_tester_pkg.sv
// Shared types and defaults for the exhaustive combinational circuit tester.
package circuit_tester_pkg;

    localparam int unsigned DefaultNIn          = 3;
    localparam int unsigned DefaultSettleCycles = 2;
    localparam int unsigned CntWidth            = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/circuit_tester_settle_timer.sv
// Settle down-counter: loads a cycle count and reports when the current edge
// brings it to zero.
module settle_timer
    import circuit_tester_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CntWidth-1:0] load_value,
    output logic                expired
);

    logic [CntWidth-1:0] count_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - CntWidth'(1);
        end
    end

    // High when the coming edge takes the count to zero.
    always_comb begin
        expired = (count_q <= CntWidth'(1));
    end

endmodule

// File: rtl/circuit_tester.sv
// Exhaustive truth-table tester: walks every input vector, lets the external
// combinational DUT settle, samples its output and compares with a golden table.
module circuit_tester
    import circuit_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles,
    parameter int unsigned N_IN          = DefaultNIn
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      fail_index
);

    localparam int unsigned         NVec       = 2 ** N_IN;
    localparam logic [N_IN-1:0]     LastVec    = N_IN'(NVec - 1);
    localparam logic [N_IN-1:0]     OneVec     = N_IN'(1);
    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES);
    // With no settle time every vector goes straight to sampling.
    localparam state_e              AfterLoad  = (SETTLE_CYCLES == 0) ? StSample : StSettle;

    state_e          state_q;
    logic [NVec-1:0] expected_q;
    logic            load;
    logic            expired;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (SettleLoad),
        .expired    (expired)
    );

    // Reload the settle time at sweep start and on every vector advance.
    always_comb begin
        load = 1'b0;
        if (state_q == StIdle && start) begin
            load = 1'b1;
        end
        if (state_q == StSample && dut_in != LastVec) begin
            load = 1'b1;
        end
    end

    // Sweep FSM with vector register, capture/compare and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            expected_q <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            captured   <= '0;
            fail_valid <= 1'b0;
            fail_index <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        expected_q <= expected;
                        captured   <= '0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_index <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b1;
                        state_q    <= AfterLoad;
                    end
                end
                StSettle: begin
                    if (expired) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    captured[dut_in] <= dut_f;
                    // Only the first mismatch of a sweep is recorded.
                    if (dut_f != expected_q[dut_in] && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_index <= dut_in;
                    end
                    if (dut_in == LastVec) begin
                        dut_in  <= '0;
                        state_q <= StDone;
                    end else begin
                        dut_in  <= dut_in + OneVec;
                        state_q <= AfterLoad;
                    end
                end
                StDone: begin
                    // captured is complete here, so the verdict is taken now.
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (captured == expected_q);
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuit_tester.sv
// Self-checking bench for circuit_tester: table-driven DUT models, randomized
// sweeps and a reference model computed directly from the truth-table rules.
module tb_circuit_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Instance with default settle time.
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [2:0] dut_in;
    logic       dut_f;
    logic       busy, done, pass, fail_valid;
    logic [7:0] captured;
    logic [2:0] fail_index;
    logic [7:0] tt = 8'h00;

    // Instance with zero settle time.
    logic       z_start = 1'b0;
    logic [7:0] z_expected = 8'h00;
    logic [2:0] z_dut_in;
    logic       z_dut_f;
    logic       z_busy, z_done, z_pass, z_fail_valid;
    logic [7:0] z_captured;
    logic [2:0] z_fail_index;
    logic [7:0] z_tt = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The combinational circuits under test are pure truth-table lookups.
    assign dut_f   = tt[dut_in];
    assign z_dut_f = z_tt[z_dut_in];

    circuit_tester #(.SETTLE_CYCLES(2), .N_IN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .expected   (expected),
        .dut_in     (dut_in),
        .dut_f      (dut_f),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .captured   (captured),
        .fail_valid (fail_valid),
        .fail_index (fail_index)
    );

    circuit_tester #(.SETTLE_CYCLES(0), .N_IN(3)) dut_z (
        .clk        (clk),
        .rst        (rst),
        .start      (z_start),
        .expected   (z_expected),
        .dut_in     (z_dut_in),
        .dut_f      (z_dut_f),
        .busy       (z_busy),
        .done       (z_done),
        .pass       (z_pass),
        .captured   (z_captured),
        .fail_valid (z_fail_valid),
        .fail_index (z_fail_index)
    );

    // F = (A&B) | (~A&C) | (A&~B&~C), A = MSB of the vector index.
    function automatic logic [7:0] table_of_f();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            a = ((i >> 2) & 1) != 0;
            b = ((i >> 1) & 1) != 0;
            c = (i & 1) != 0;
            t[i] = (a & b) | (~a & c) | (a & ~b & ~c);
        end
        return t;
    endfunction

    function automatic int lowest_diff(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (a[i] != b[i]) return i;
        end
        return 0;
    endfunction

    // Runs one sweep on the default instance; reports the done cycle (relative
    // to the accepting edge) and whether dut_in/busy followed the schedule.
    task automatic do_sweep(input logic [7:0] exp_tt, input bit poke,
                            output int done_at, output bit seq_ok);
        int ev;
        @(negedge clk);
        expected = exp_tt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        expected = 8'($urandom);
        seq_ok   = 1'b1;
        done_at  = -1;
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke) start = (n == 3 || n == 10);
            ev = (n < 24) ? n / 3 : 0;
            if (dut_in !== ev[2:0]) seq_ok = 1'b0;
            if (busy !== (n < 25)) seq_ok = 1'b0;
            if (done === 1'b1) done_at = n;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, done, pass, fail_valid, dut_in, fail_index, captured} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, pass, fail_valid, dut_in, fail_index, captured});
        end
        checks++;
        if ({z_busy, z_done, z_pass, z_fail_valid, z_dut_in, z_fail_index, z_captured}
            !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs_z: got %h want 0",
                     {z_busy, z_done, z_pass, z_fail_valid, z_dut_in, z_fail_index, z_captured});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_golden();
        int done_at;
        bit seq_ok;
        tt = table_of_f();
        do_sweep(8'hDA, 1'b0, done_at, seq_ok);
        checks++;
        if (done_at != 25) begin
            errors++;
            $display("FAIL golden_latency: got %0d want 25", done_at);
        end
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL golden_schedule: got 0 want 1");
        end
        checks++;
        if ({captured, pass, fail_valid, fail_index} !== {8'hDA, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL golden_result: got cap=%h pass=%b fv=%b fi=%0d want cap=da pass=1 fv=0 fi=0",
                     captured, pass, fail_valid, fail_index);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, captured, pass} !== {1'b0, 1'b0, 8'hDA, 1'b1}) begin
            errors++;
            $display("FAIL golden_hold: got done=%b busy=%b cap=%h pass=%b want 0 0 da 1",
                     done, busy, captured, pass);
        end
    endtask

    task automatic test_mismatch();
        int done_at;
        bit seq_ok;
        tt = table_of_f();
        do_sweep(8'hDB, 1'b0, done_at, seq_ok);
        checks++;
        if ({captured, pass, fail_valid, fail_index} !== {8'hDA, 1'b0, 1'b1, 3'd0}
            || done_at != 25) begin
            errors++;
            $display("FAIL mismatch_db: got cap=%h pass=%b fv=%b fi=%0d at=%0d want da 0 1 0 25",
                     captured, pass, fail_valid, fail_index, done_at);
        end
    endtask

    task automatic test_stuck();
        int done_at;
        bit seq_ok;
        tt = 8'hFF;
        do_sweep(8'hDA, 1'b0, done_at, seq_ok);
        checks++;
        if ({captured, pass, fail_valid, fail_index} !== {8'hFF, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL stuck_at_1: got cap=%h pass=%b fv=%b fi=%0d want ff 0 1 0",
                     captured, pass, fail_valid, fail_index);
        end
        tt = 8'h00;
        do_sweep(8'hDA, 1'b0, done_at, seq_ok);
        checks++;
        if ({captured, pass, fail_valid, fail_index} !== {8'h00, 1'b0, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL stuck_at_0: got cap=%h pass=%b fv=%b fi=%0d want 00 0 1 1",
                     captured, pass, fail_valid, fail_index);
        end
    endtask

    task automatic test_random();
        int done_at;
        bit seq_ok;
        logic [7:0] exp_tt;
        logic [2:0] want_fi;
        for (int k = 0; k < 6; k++) begin
            tt = 8'($urandom);
            exp_tt = ($urandom_range(0, 2) == 0) ? tt : 8'($urandom);
            want_fi = 3'(lowest_diff(tt, exp_tt));
            do_sweep(exp_tt, (k % 2) == 1, done_at, seq_ok);
            checks++;
            if (captured !== tt || pass !== (tt == exp_tt) || fail_valid !== (tt != exp_tt)
                || fail_index !== want_fi || done_at != 25 || !seq_ok) begin
                errors++;
                $display("FAIL random_%0d: got cap=%h pass=%b fv=%b fi=%0d at=%0d seq=%b want cap=%h pass=%b fv=%b fi=%0d at=25 seq=1",
                         k, captured, pass, fail_valid, fail_index, done_at, seq_ok,
                         tt, tt == exp_tt, tt != exp_tt, want_fi);
            end
        end
    endtask

    task automatic test_ignore_start();
        int done_at;
        bit seq_ok;
        tt = table_of_f();
        do_sweep(8'hDA, 1'b1, done_at, seq_ok);
        checks++;
        if (done_at != 25 || !seq_ok || pass !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start: got at=%0d seq=%b pass=%b want 25 1 1",
                     done_at, seq_ok, pass);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_single_done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_zero_settle();
        int done_at;
        bit seq_ok;
        z_tt = 8'hAA;
        @(negedge clk);
        z_expected = 8'hAA;
        z_start    = 1'b1;
        @(posedge clk);
        #1;
        z_start = 1'b0;
        done_at = -1;
        seq_ok  = 1'b1;
        for (int n = 0; n < 30 && done_at < 0; n++) begin
            int ev;
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            ev = (n < 8) ? n : 0;
            if (z_dut_in !== ev[2:0]) seq_ok = 1'b0;
            if (z_done === 1'b1) done_at = n;
        end
        checks++;
        if (done_at != 9 || !seq_ok) begin
            errors++;
            $display("FAIL zero_settle_timing: got at=%0d seq=%b want 9 1", done_at, seq_ok);
        end
        checks++;
        if ({z_captured, z_pass, z_fail_valid} !== {8'hAA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_settle_result: got cap=%h pass=%b fv=%b want aa 1 0",
                     z_captured, z_pass, z_fail_valid);
        end
    endtask

    task automatic test_reset_mid();
        int done_at;
        bit seq_ok;
        bit found;
        bit saw_done;
        tt = 8'hFF;
        @(negedge clk);
        expected = 8'hDA;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (dut_in === 3'd5) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach_v5: got 0 want 1");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, fail_valid, dut_in, fail_index, captured} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want 0",
                     {busy, done, pass, fail_valid, dut_in, fail_index, captured});
        end
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_no_done: got 1 want 0");
        end
        tt = table_of_f();
        do_sweep(8'hDA, 1'b0, done_at, seq_ok);
        checks++;
        if (done_at != 25 || !seq_ok || captured !== 8'hDA || pass !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fresh_sweep: got at=%0d seq=%b cap=%h pass=%b want 25 1 da 1",
                     done_at, seq_ok, captured, pass);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        bit busy_ok;
        tt = table_of_f();
        @(negedge clk);
        expected = 8'hDA;
        start    = 1'b1;
        @(posedge clk);
        #1;
        busy_ok = 1'b1;
        for (int n = 0; n <= 52; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n == 51) start = 1'b0;
            if (done === 1'b1) dones.push_back(n);
            if (busy !== !(n == 25 || n >= 51)) busy_ok = 1'b0;
        end
        checks++;
        if (dones.size() != 2 || dones[0] != 25 || dones[1] != 51) begin
            errors++;
            $display("FAIL back_to_back_dones: got n=%0d first=%0d second=%0d want 2 25 51",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1,
                     (dones.size() > 1) ? dones[1] : -1);
        end
        checks++;
        if (!busy_ok || pass !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_busy: got busy_ok=%b pass=%b want 1 1", busy_ok, pass);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_stuck();
        test_random();
        test_ignore_start();
        test_zero_settle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
